// File: rtl/instruction_assembler_pkg.sv
// Shared defaults and size helpers for the instruction assembler.
// Holds beat/instruction widths and the beat-count/counter-width math.
package instruction_assembler_pkg;

  localparam int DEF_IN_W   = 8;
  localparam int DEF_INST_W = 32;

  function automatic int beats_of(
    input int inst_w,
    input int in_w
  );
    return inst_w / in_w;
  endfunction

  function automatic int cnt_w_of(
    input int beats
  );
    return $clog2(beats);
  endfunction

  localparam int DEF_BEATS = beats_of(DEF_INST_W, DEF_IN_W);
  localparam int DEF_CNT_W = cnt_w_of(DEF_BEATS);

endpackage

// File: rtl/instruction_assembler_if.sv
// Beat-in / instruction-out handshake bundle for the assembler.
// master: beat producer + instruction consumer; slave: the assembler.
interface instruction_assembler_if
  import instruction_assembler_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int INST_W = DEF_INST_W
);

  localparam int CNT_W = cnt_w_of(beats_of(INST_W, IN_W));

  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   data_in;
  logic              flush;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_out;
  logic [CNT_W-1:0]  beat_cnt;

  modport master (
    output in_valid,
    output data_in,
    output flush,
    output inst_ready,
    input  in_ready,
    input  inst_valid,
    input  inst_out,
    input  beat_cnt
  );

  modport slave (
    input  in_valid,
    input  data_in,
    input  flush,
    input  inst_ready,
    output in_ready,
    output inst_valid,
    output inst_out,
    output beat_cnt
  );

endinterface

// File: rtl/instruction_assembler.sv
// Packs BEATS narrow beats into one INST_W instruction word.
// Ports: clk, rst_n (async low), bus (slave: beats in, words out).
module instruction_assembler
  import instruction_assembler_pkg::*;
#(
  parameter int IN_W       = DEF_IN_W,
  parameter int INST_W     = DEF_INST_W,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input logic                  clk,
  input logic                  rst_n,
  instruction_assembler_if.slave bus
);

  localparam int BEATS = beats_of(INST_W, IN_W);
  localparam int CNT_W = cnt_w_of(BEATS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0]  cnt;
  logic [INST_W-1:0] part;
  logic [INST_W-1:0] part_ins;
  logic [INST_W-1:0] out_q;
  logic              out_v;
  logic              last;
  logic              in_rdy;
  logic              accept;
  logic              fire;

  assign last   = (cnt == LAST);
  // Only the final beat needs the output slot free.
  assign in_rdy = !last || !out_v || bus.inst_ready;
  assign accept = bus.in_valid && in_rdy && !bus.flush;
  assign fire   = accept && last;

  // Partial word with the current beat dropped into its slot.
  always_comb begin
    part_ins = part;
    for (int k = 0; k < BEATS; k++) begin
      if (cnt == CNT_W'(BIG_ENDIAN ? BEATS - 1 - k : k)) begin
        part_ins[IN_W*k +: IN_W] = bus.data_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      part <= '0;
    end else if (bus.flush) begin
      cnt  <= '0;
      part <= '0;
    end else if (accept) begin
      if (last) begin
        cnt  <= '0;
        part <= '0;
      end else begin
        cnt  <= cnt + CNT_W'(1);
        part <= part_ins;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      out_v <= 1'b0;
    end else if (fire) begin
      out_q <= part_ins;
      out_v <= 1'b1;
    end else if (bus.inst_ready) begin
      out_v <= 1'b0;
    end
  end

  assign bus.in_ready   = in_rdy;
  assign bus.inst_valid = out_v;
  assign bus.inst_out   = out_q;
  assign bus.beat_cnt   = cnt;

endmodule

// File: tb/tb_instruction_assembler.sv
// Scoreboard bench: LE 8/32, BE 8/32 and LE 16/64 assemblers.
// Stimulus pushes expected words; monitors pop on each handshake.
module tb_instruction_assembler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instruction_assembler_if #(.IN_W(8), .INST_W(32)) ia ();
  instruction_assembler_if #(.IN_W(8), .INST_W(32)) ib ();
  instruction_assembler_if #(.IN_W(16), .INST_W(64)) iw ();

  instruction_assembler #(
    .IN_W(8), .INST_W(32), .BIG_ENDIAN(1'b0)
  ) u_a (.clk(clk), .rst_n(rst_n), .bus(ia));

  instruction_assembler #(
    .IN_W(8), .INST_W(32), .BIG_ENDIAN(1'b1)
  ) u_b (.clk(clk), .rst_n(rst_n), .bus(ib));

  instruction_assembler #(
    .IN_W(16), .INST_W(64), .BIG_ENDIAN(1'b0)
  ) u_w (.clk(clk), .rst_n(rst_n), .bus(iw));

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [63:0] qw[$];
  int          tw[$];

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ia.inst_valid && ia.inst_ready) begin
      if (qa.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL a_extra: got %0h want none", ia.inst_out);
      end else begin
        chk("a_word", 64'(ia.inst_out), 64'(qa.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ib.inst_valid && ib.inst_ready) begin
      if (qb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL b_extra: got %0h want none", ib.inst_out);
      end else begin
        chk("b_word", 64'(ib.inst_out), 64'(qb.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && iw.inst_valid && iw.inst_ready) begin
      tw.push_back(cyc);
      if (qw.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL w_extra: got %0h want none", iw.inst_out);
      end else begin
        chk("w_word", iw.inst_out, qw.pop_front());
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic beat_a(input logic [7:0] d);
    ia.in_valid = 1'b1;
    ia.data_in  = d;
    @(negedge clk);
    chk("a_in_ready", 64'(ia.in_ready), 64'd1);
    nxt();
    ia.in_valid = 1'b0;
  endtask

  task automatic beat_b(input logic [7:0] d);
    ib.in_valid = 1'b1;
    ib.data_in  = d;
    @(negedge clk);
    chk("b_in_ready", 64'(ib.in_ready), 64'd1);
    nxt();
    ib.in_valid = 1'b0;
  endtask

  task automatic beat_w(input logic [15:0] d);
    iw.in_valid = 1'b1;
    iw.data_in  = d;
    @(negedge clk);
    chk("w_in_ready", 64'(iw.in_ready), 64'd1);
    nxt();
    iw.in_valid = 1'b0;
  endtask

  initial begin
    ia.in_valid = 0; ia.data_in = '0;
    ia.flush = 0; ia.inst_ready = 0;
    ib.in_valid = 0; ib.data_in = '0;
    ib.flush = 0; ib.inst_ready = 0;
    iw.in_valid = 0; iw.data_in = '0;
    iw.flush = 0; iw.inst_ready = 0;

    #12;
    chk("rst_valid", 64'(ia.inst_valid), 64'd0);
    chk("rst_out", 64'(ia.inst_out), 64'd0);
    chk("rst_cnt", 64'(ia.beat_cnt), 64'd0);
    nxt();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(ia.in_ready), 64'd1);
    nxt();

    // Basic little-endian word, 1-cycle latency
    ia.inst_ready = 1'b1;
    qa.push_back(32'h44332211);
    beat_a(8'h11);
    beat_a(8'h22);
    beat_a(8'h33);
    chk("le_cnt3", 64'(ia.beat_cnt), 64'd3);
    chk("le_nv", 64'(ia.inst_valid), 64'd0);
    beat_a(8'h44);
    chk("le_lat", 64'(ia.inst_valid), 64'd1);
    chk("le_cnt0", 64'(ia.beat_cnt), 64'd0);
    nxt();
    chk("le_clr", 64'(ia.inst_valid), 64'd0);

    // Backpressure: second word stalls on its final beat
    ia.inst_ready = 1'b0;
    qa.push_back(32'h44332211);
    qa.push_back(32'h88776655);
    beat_a(8'h11);
    beat_a(8'h22);
    beat_a(8'h33);
    beat_a(8'h44);
    beat_a(8'h55);
    beat_a(8'h66);
    beat_a(8'h77);
    ia.in_valid = 1'b1;
    ia.data_in  = 8'h88;
    @(negedge clk);
    chk("bp_in_ready", 64'(ia.in_ready), 64'd0);
    chk("bp_cnt", 64'(ia.beat_cnt), 64'd3);
    chk("bp_valid", 64'(ia.inst_valid), 64'd1);
    chk("bp_hold1", 64'(ia.inst_out), 64'h44332211);
    nxt();
    @(negedge clk);
    chk("bp_hold2", 64'(ia.inst_out), 64'h44332211);
    chk("bp_cnt2", 64'(ia.beat_cnt), 64'd3);
    nxt();
    ia.inst_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_rdy", 64'(ia.in_ready), 64'd1);
    nxt();
    ia.in_valid   = 1'b0;
    ia.inst_ready = 1'b0;
    chk("bp_b2b_v", 64'(ia.inst_valid), 64'd1);
    chk("bp_w2", 64'(ia.inst_out), 64'h88776655);
    chk("bp_cnt0", 64'(ia.beat_cnt), 64'd0);
    ia.inst_ready = 1'b1;
    nxt();
    chk("bp_clr", 64'(ia.inst_valid), 64'd0);

    // Flush discards partial word, including the coincident beat
    beat_a(8'hAA);
    beat_a(8'hBB);
    ia.flush    = 1'b1;
    ia.in_valid = 1'b1;
    ia.data_in  = 8'hCC;
    nxt();
    ia.flush    = 1'b0;
    ia.in_valid = 1'b0;
    chk("fl_cnt0", 64'(ia.beat_cnt), 64'd0);
    chk("fl_nv", 64'(ia.inst_valid), 64'd0);
    ia.inst_ready = 1'b0;
    qa.push_back(32'h04030201);
    beat_a(8'h01);
    beat_a(8'h02);
    beat_a(8'h03);
    beat_a(8'h04);
    beat_a(8'h05);
    beat_a(8'h06);
    // Flush with consume in the same cycle
    ia.flush      = 1'b1;
    ia.inst_ready = 1'b1;
    ia.in_valid   = 1'b1;
    ia.data_in    = 8'h07;
    nxt();
    ia.flush    = 1'b0;
    ia.in_valid = 1'b0;
    chk("flc_cnt0", 64'(ia.beat_cnt), 64'd0);
    chk("flc_nv", 64'(ia.inst_valid), 64'd0);
    qa.push_back(32'h0C0B0A09);
    beat_a(8'h09);
    beat_a(8'h0A);
    beat_a(8'h0B);
    beat_a(8'h0C);
    nxt();

    // Asynchronous reset mid-instruction
    beat_a(8'h01);
    beat_a(8'h02);
    beat_a(8'h03);
    chk("ar_pre_cnt", 64'(ia.beat_cnt), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_cnt", 64'(ia.beat_cnt), 64'd0);
    chk("ar_out", 64'(ia.inst_out), 64'd0);
    chk("ar_valid", 64'(ia.inst_valid), 64'd0);
    chk("ar_in_ready", 64'(ia.in_ready), 64'd1);
    nxt();
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_nv", 64'(ia.inst_valid), 64'd0);
    nxt();
    qa.push_back(32'hEFBEADDE);
    beat_a(8'hDE);
    beat_a(8'hAD);
    beat_a(8'hBE);
    beat_a(8'hEF);
    chk("ar_word_v", 64'(ia.inst_valid), 64'd1);
    nxt();

    // Big-endian placement
    ib.inst_ready = 1'b1;
    qb.push_back(32'h11223344);
    beat_b(8'h11);
    beat_b(8'h22);
    beat_b(8'h33);
    beat_b(8'h44);
    chk("be_lat", 64'(ib.inst_valid), 64'd1);
    nxt();

    // Wide config, continuous stream
    iw.inst_ready = 1'b1;
    qw.push_back(64'h0004_0003_0002_0001);
    qw.push_back(64'h0008_0007_0006_0005);
    qw.push_back(64'h000C_000B_000A_0009);
    for (int i = 1; i <= 12; i++) begin
      beat_w(16'(i));
    end
    nxt();
    nxt();
    chk("w_count", 64'(tw.size()), 64'd3);
    for (int i = 1; i < tw.size(); i++) begin
      chk("w_period", 64'(tw[i] - tw[i-1]), 64'd4);
    end

    chk("a_drain", 64'(qa.size()), 64'd0);
    chk("b_drain", 64'(qb.size()), 64'd0);
    chk("w_drain", 64'(qw.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_assembler.md
INSTRUCTION_ASSEMBLER -- requirements
Module: instruction_assembler

Interface
REQ-001 Parameter IN_W, default 8, width of one input beat in bits.
REQ-002 Parameter INST_W, default 32, assembled instruction width; SHALL be an integer multiple of IN_W, and BEATS = INST_W/IN_W SHALL be >= 2.
REQ-003 Parameter BIG_ENDIAN, default 0; 0 means first beat lands in LSBs, 1 means first beat lands in MSBs.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  data_in holds a valid beat.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 data_in  input  IN_W  instruction beat.
REQ-009 flush  input  1  discards the partially assembled instruction.
REQ-010 inst_valid  output  1  inst_out holds a complete instruction.
REQ-011 inst_ready  input  1  consumer takes inst_out this cycle.
REQ-012 inst_out  output  INST_W  assembled instruction, registered.
REQ-013 beat_cnt  output  clog2(BEATS)  beats collected toward the current instruction.

Function
REQ-014 A beat SHALL be accepted on a rising edge when in_valid and in_ready are both high and flush is low.
REQ-015 Beat k (k = 0..BEATS-1) SHALL be written to bits [IN_W*k +: IN_W] when BIG_ENDIAN=0, and to bits [IN_W*(BEATS-1-k) +: IN_W] when BIG_ENDIAN=1.
REQ-016 beat_cnt SHALL increment on each accepted beat and wrap from BEATS-1 to 0 on acceptance of the final beat.
REQ-017 On acceptance of the final beat, the full word SHALL be copied into the inst_out register, and inst_valid SHALL be high in the next cycle (1-cycle latency).
REQ-018 The final beat may be accepted in the same cycle as the previous instruction is consumed, giving back-to-back output with no bubble.
REQ-019 in_ready = (beat_cnt != BEATS-1) OR NOT inst_valid OR inst_ready, so that non-final beats are accepted while an output is held.
REQ-020 inst_valid and inst_out SHALL hold stable while inst_valid=1 and inst_ready=0.
REQ-021 inst_valid SHALL clear after a cycle with inst_ready=1, unless a new final beat is accepted in that same cycle.
REQ-022 Flush SHALL zero beat_cnt and the partial word on the next edge, leaving inst_valid and inst_out untouched.
REQ-023 Flush coincident with in_valid SHALL discard that beat; flush takes priority.
REQ-024 Flush coincident with inst_ready SHALL still allow the output to be consumed.
REQ-025 Bits not yet written in the partial word SHALL read zero after reset or flush.

Reset
REQ-026 rst_n low SHALL immediately clear beat_cnt, the partial word, inst_out (all zero) and inst_valid, independent of clk.
REQ-027 After rst_n deasserts, in_ready SHALL be 1 and the first accepted beat SHALL be beat 0.
REQ-028 Reset asserted mid-instruction SHALL discard all collected beats; no partial output is produced.

Structure
REQ-029 Default IN_W/INST_W values and the BEATS and counter-width derivations SHALL reside in the shared package.
REQ-030 No sub-module is required; the block SHALL be one module with a counter, a partial-word register and an output register.

Verification
REQ-031 IN_W=8, INST_W=32, LE: beats 0x11,0x22,0x33,0x44 on consecutive cycles -> inst_out=0x44332211, inst_valid high 1 cycle after the 4th beat.
REQ-032 Same beats with BIG_ENDIAN=1 -> inst_out=0x11223344.
REQ-033 inst_ready held low with a 2nd instruction streamed -> 3 beats accepted, in_ready=0 at beat_cnt=3, inst_out stays 0x44332211 until inst_ready=1, then 2nd word appears the next cycle.
REQ-034 Flush after beats 0xAA,0xBB, then 0x01..0x04 -> inst_out=0x04030201, beat_cnt=0 the cycle after flush.
REQ-035 rst_n pulsed low asynchronously after 3 beats -> outputs zero immediately, no inst_valid; the next 4 beats form a clean word.
REQ-036 IN_W=16, INST_W=64, continuous in_valid and inst_ready -> one inst_valid every 4 cycles, no dropped beats.
